// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder with four 8-bit registers, sampled in the clk domain.
// Rev 1.0
`default_nettype none

module spi_target #(
  parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCK,
  input  logic        CSX,
  input  logic        SDI,
  input  logic [7:0]  status,
  output logic        SDO,
  output logic [31:0] regs,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_FULL = 2'd3
  } state_t;

  logic [2:0]  r_sck_s;
  logic [2:0]  r_csx_s;
  logic [1:0]  r_sdi_s;
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [6:0]  r_sin;
  logic [7:0]  r_sout;
  logic        r_sdo;
  logic        r_wr;
  logic [1:0]  r_addr;
  logic [7:0]  r_data;
  logic [31:0] r_regs;
  logic        r_done;

  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_csx_rise;
  logic        w_csx_fall;
  logic [7:0]  w_byte;

  // Reset to 0 so a CSX already low at reset release never looks like a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_s <= 3'b000;
      r_csx_s <= 3'b000;
      r_sdi_s <= 2'b00;
    end else begin
      r_sck_s <= {r_sck_s[1:0], SCK};
      r_csx_s <= {r_csx_s[1:0], CSX};
      r_sdi_s <= {r_sdi_s[0], SDI};
    end
  end

  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
  assign w_csx_rise = r_csx_s[1] & ~r_csx_s[2];
  assign w_csx_fall = ~r_csx_s[1] & r_csx_s[2];
  assign w_byte     = {r_sin, r_sdi_s[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_sin   <= 7'd0;
      r_sout  <= 8'd0;
      r_sdo   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 2'd0;
      r_data  <= 8'd0;
      r_regs  <= REG_INIT;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sdo <= 1'b0;
          r_cnt <= 5'd0;
          if (w_csx_fall) begin
            r_sout  <= {status[6:0], 1'b0};
            r_sdo   <= status[7];
            r_state <= S_CMD;
          end
        end
        S_CMD, S_DATA: begin
          // CSX edges win over a coincident SCK edge.
          if (w_csx_rise) begin
            r_sdo   <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_sck_rise) begin
            r_sin <= w_byte[6:0];
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd7) begin
              r_wr    <= w_byte[7];
              r_addr  <= w_byte[1:0];
              r_sout  <= r_regs[{w_byte[1:0], 3'b000} +: 8];
              r_state <= S_DATA;
            end else if (r_cnt == 5'd15) begin
              r_data  <= w_byte;
              r_sdo   <= 1'b0;
              r_state <= S_FULL;
            end
          end else if (w_sck_fall) begin
            r_sdo  <= r_sout[7];
            r_sout <= {r_sout[6:0], 1'b0};
          end
        end
        S_FULL: begin
          r_sdo <= 1'b0;
          if (w_csx_rise) begin
            if (r_wr) begin
              r_regs[{r_addr, 3'b000} +: 8] <= r_data;
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SDO  = r_sdo;
  assign regs = r_regs;
  assign done = r_done;
  assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
